// File: rtl/mem_wb_stage.sv
// mem_wb_stage: single-entry MEM->WB pipeline register with load-data
// extraction from a synchronous RAM and a forwarding tap toward earlier stages.
module mem_wb_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            me_valid,
  output logic            me_ready,
  input  logic [XLEN-1:0] me_alu_o,
  input  logic [RA_W-1:0] me_rd,
  input  logic            me_mem2reg,
  input  logic            me_regs_write,
  input  logic [2:0]      me_func3_code,
  input  logic [XLEN-1:0] me_mem_data,
  input  logic            flush,
  input  logic            wb_ready,
  output logic            wb_valid,
  output logic [RA_W-1:0] wb_rd,
  output logic            wb_regs_write,
  output logic [XLEN-1:0] wb_wdata,
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  localparam int OFS_W = $clog2(XLEN / 8);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_FULL      = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [XLEN-1:0]   alu_r;
  logic [XLEN-1:0]   data_r;
  logic [RA_W-1:0]   rd_r;
  logic [2:0]        func3_r;
  logic [OFS_W-1:0]  ofs_r;
  logic              mem2reg_r;
  logic              regs_write_r;
  logic              accept_s;
  logic [XLEN-1:0]   load_val_s;

  // Pick the addressed lane of the RAM word and extend it according to func3.
  // Misaligned offsets are rounded down to the access size; no fault is raised.
  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0]  raw,
    input logic [2:0]       f3,
    input logic [OFS_W-1:0] ofs
  );
    logic [OFS_W-1:0] h_ofs;
    logic [OFS_W-1:0] w_ofs;
    logic [7:0]       b_v;
    logic [15:0]      h_v;
    logic [31:0]      w_v;
    logic [XLEN-1:0]  res;
    h_ofs = ofs & ~OFS_W'(1);
    w_ofs = ofs & ~OFS_W'(3);
    b_v   = 8'(raw >> {ofs, 3'b000});
    h_v   = 16'(raw >> {h_ofs, 3'b000});
    w_v   = 32'(raw >> {w_ofs, 3'b000});
    case (f3)
      3'b000:  res = XLEN'($signed(b_v));
      3'b001:  res = XLEN'($signed(h_v));
      3'b010:  res = XLEN'($signed(w_v));
      3'b100:  res = XLEN'(b_v);
      3'b101:  res = XLEN'(h_v);
      3'b110:  res = (XLEN == 64) ? XLEN'(w_v) : raw;
      default: res = raw;   // LD at XLEN=64 and all undefined codes
    endcase
    return res;
  endfunction

  assign me_ready = (state_r == ST_EMPTY) | ((state_r == ST_FULL) & wb_ready) | flush;
  assign accept_s = me_valid & me_ready & ~flush;

  // Next-state selection; flush overrides everything and drops any pending load.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = me_mem2reg ? ST_WAIT_DATA : ST_FULL;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_WAIT_DATA: begin
          state_nxt_s = ST_FULL;
        end
        ST_FULL: begin
          if (accept_s) begin
            state_nxt_s = me_mem2reg ? ST_WAIT_DATA : ST_FULL;
          end else if (wb_ready) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Entry fields: captured on accept; RAM data lands during the WAIT_DATA cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_r        <= {XLEN{1'b0}};
      data_r       <= {XLEN{1'b0}};
      rd_r         <= {RA_W{1'b0}};
      func3_r      <= 3'b000;
      ofs_r        <= {OFS_W{1'b0}};
      mem2reg_r    <= 1'b0;
      regs_write_r <= 1'b0;
    end else if (accept_s) begin
      alu_r        <= me_alu_o;
      rd_r         <= me_rd;
      func3_r      <= me_func3_code;
      ofs_r        <= me_alu_o[OFS_W-1:0];
      mem2reg_r    <= me_mem2reg;
      regs_write_r <= me_regs_write;
    end else if ((state_r == ST_WAIT_DATA) && !flush) begin
      data_r       <= me_mem_data;
    end
  end

  assign load_val_s    = load_extract(data_r, func3_r, ofs_r);
  assign wb_valid      = (state_r == ST_FULL);
  assign wb_rd         = rd_r;
  assign wb_wdata      = mem2reg_r ? load_val_s : alu_r;
  assign wb_regs_write = regs_write_r & (rd_r != {RA_W{1'b0}}) & wb_valid;
  assign fwd_valid     = wb_regs_write;
  assign fwd_rd        = wb_rd;
  assign fwd_data      = wb_wdata;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized traffic compared
// against a transaction-level reference model (XLEN=32), and a small XLEN=64
// instance for the 64-bit-only load codes.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        me_valid, me_mem2reg, me_regs_write, flush, wb_ready;
  logic [31:0] me_alu_o, me_mem_data;
  logic [4:0]  me_rd;
  logic [2:0]  me_func3_code;
  logic        me_ready, wb_valid, wb_regs_write, fwd_valid;
  logic [4:0]  wb_rd, fwd_rd;
  logic [31:0] wb_wdata, fwd_data;

  logic        v64, m2r64, rw64, fl64, wr64;
  logic [63:0] alu64, md64;
  logic [4:0]  rd64;
  logic [2:0]  f3_64;
  logic        rdy64, wbv64, wbrw64, fwdv64;
  logic [4:0]  wbrd64, fwdrd64;
  logic [63:0] wbd64, fwdd64;

  mem_wb_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rstn(rstn), .me_valid(me_valid), .me_ready(me_ready),
    .me_alu_o(me_alu_o), .me_rd(me_rd), .me_mem2reg(me_mem2reg),
    .me_regs_write(me_regs_write), .me_func3_code(me_func3_code),
    .me_mem_data(me_mem_data), .flush(flush), .wb_ready(wb_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regs_write(wb_regs_write),
    .wb_wdata(wb_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  mem_wb_stage #(.XLEN(64), .RA_W(5)) dut64 (
    .clk(clk), .rstn(rstn), .me_valid(v64), .me_ready(rdy64),
    .me_alu_o(alu64), .me_rd(rd64), .me_mem2reg(m2r64),
    .me_regs_write(rw64), .me_func3_code(f3_64),
    .me_mem_data(md64), .flush(fl64), .wb_ready(wr64),
    .wb_valid(wbv64), .wb_rd(wbrd64), .wb_regs_write(wbrw64),
    .wb_wdata(wbd64), .fwd_valid(fwdv64), .fwd_rd(fwdrd64), .fwd_data(fwdd64)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: one held transaction, plus whether its RAM data is still outstanding.
  bit          m_have, m_wait, m_m2r, m_rw;
  logic [31:0] m_alu, m_data;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Load result computed arithmetically from the RISC-V load rules.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input int ofs, input logic [2:0] f3);
    longint b, h;
    b = (longint'(word) >> (8 * ofs)) & 255;
    h = (longint'(word) >> (16 * (ofs / 2))) & 65535;
    case (f3)
      3'd0:    return 32'((b >= 128) ? b - 256 : b);
      3'd1:    return 32'((h >= 32768) ? h - 65536 : h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return word;
    endcase
  endfunction

  task automatic model_reset();
    m_have = 1'b0; m_wait = 1'b0;
  endtask

  task automatic check_model();
    bit          ev, erw;
    logic [31:0] ed;
    ev  = m_have && !m_wait;
    erw = ev && m_rw && (m_rd != 5'd0);
    ed  = m_m2r ? ref_load(m_data, int'(m_alu[1:0]), m_f3) : m_alu;
    check_val("me_ready", me_ready, !m_have || (ev && wb_ready) || flush);
    check_val("wb_valid", wb_valid, ev);
    check_val("wb_regs_write", wb_regs_write, erw);
    check_val("fwd_valid", fwd_valid, erw);
    if (ev) begin
      check_val("wb_rd", wb_rd, m_rd);
      check_val("wb_wdata", wb_wdata, ed);
      check_val("fwd_rd", fwd_rd, m_rd);
      check_val("fwd_data", fwd_data, ed);
    end
  endtask

  task automatic update_model();
    bit rdy, acc;
    rdy = !m_have || (!m_wait && wb_ready) || flush;
    acc = me_valid && rdy && !flush;
    if (flush) begin
      m_have = 1'b0;
    end else if (acc) begin
      m_have = 1'b1; m_wait = me_mem2reg; m_alu = me_alu_o; m_rd = me_rd;
      m_m2r = me_mem2reg; m_rw = me_regs_write; m_f3 = me_func3_code;
    end else if (m_have && m_wait) begin
      m_data = me_mem_data; m_wait = 1'b0;
    end else if (m_have && wb_ready) begin
      m_have = 1'b0;
    end
  endtask

  // One clock: drive at negedge, check outputs, advance model at posedge, return 1 ns later.
  task automatic step(input bit v, input logic [31:0] alu, input logic [4:0] rd, input bit m2r,
                      input bit rw, input logic [2:0] f3, input logic [31:0] md,
                      input bit fl, input bit wr);
    @(negedge clk);
    me_valid = v; me_alu_o = alu; me_rd = rd; me_mem2reg = m2r; me_regs_write = rw;
    me_func3_code = f3; me_mem_data = md; flush = fl; wb_ready = wr;
    #1;
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle(input logic [31:0] md, input bit fl, input bit wr);
    step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0, md, fl, wr);
  endtask

  task automatic step64(input bit v, input logic [63:0] alu, input bit m2r,
                        input logic [2:0] f3, input logic [63:0] md);
    @(negedge clk);
    v64 = v; alu64 = alu; rd64 = 5'd3; m2r64 = m2r; rw64 = 1'b1; f3_64 = f3;
    md64 = md; fl64 = 1'b0; wr64 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_wb_valid"}, wb_valid, 1'b0);
    check_val({tag, "_wb_regs_write"}, wb_regs_write, 1'b0);
    check_val({tag, "_fwd_valid"}, fwd_valid, 1'b0);
    check_val({tag, "_wb_rd"}, wb_rd, 5'd0);
    check_val({tag, "_wb_wdata"}, wb_wdata, 32'h0);
  endtask

  initial begin
    rstn = 1'b0;
    me_valid = 1'b0; me_alu_o = 32'h0; me_rd = 5'd0; me_mem2reg = 1'b0;
    me_regs_write = 1'b0; me_func3_code = 3'd0; me_mem_data = 32'h0;
    flush = 1'b0; wb_ready = 1'b0;
    v64 = 1'b0; alu64 = 64'h0; rd64 = 5'd0; m2r64 = 1'b0; rw64 = 1'b0;
    f3_64 = 3'd0; md64 = 64'h0; fl64 = 1'b0; wr64 = 1'b1;
    model_reset();
    m_alu = 32'h0; m_data = 32'h0; m_rd = 5'd0; m_m2r = 1'b0; m_rw = 1'b0; m_f3 = 3'd0;
    #3;
    check_all_zero("reset");
    #9 rstn = 1'b1;
    #1;
    check_val("ready_after_reset", me_ready, 1'b1);

    // ADD rd=5
    step(1'b1, 32'h1234, 5'd5, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b1);
    check_val("add_valid", wb_valid, 1'b1);
    check_val("add_rd", wb_rd, 5'd5);
    check_val("add_wdata", wb_wdata, 32'h00001234);
    check_val("add_we", wb_regs_write, 1'b1);
    check_val("add_fwd", fwd_valid, 1'b1);

    // LB / LBU at offset 3, back-to-back from FULL
    step(1'b1, 32'h1003, 5'd6, 1'b1, 1'b1, 3'b000, 32'h0, 1'b0, 1'b1);
    check_val("lb_ready_bubble", me_ready, 1'b0);
    check_val("lb_valid_bubble", wb_valid, 1'b0);
    idle(32'h80FF0102, 1'b0, 1'b1);
    check_val("lb_wdata", wb_wdata, 32'hFFFFFF80);
    step(1'b1, 32'h1003, 5'd6, 1'b1, 1'b1, 3'b100, 32'h0, 1'b0, 1'b1);
    idle(32'h80FF0102, 1'b0, 1'b1);
    check_val("lbu_wdata", wb_wdata, 32'h00000080);

    // LHU / LH at offset 2, then misaligned LH at offset 3 rounds down to 2
    step(1'b1, 32'h2002, 5'd7, 1'b1, 1'b1, 3'b101, 32'h0, 1'b0, 1'b1);
    idle(32'hBEEF1234, 1'b0, 1'b1);
    check_val("lhu_wdata", wb_wdata, 32'h0000BEEF);
    step(1'b1, 32'h2002, 5'd7, 1'b1, 1'b1, 3'b001, 32'h0, 1'b0, 1'b1);
    idle(32'hBEEF1234, 1'b0, 1'b1);
    check_val("lh_wdata", wb_wdata, 32'hFFFFBEEF);
    step(1'b1, 32'h2003, 5'd7, 1'b1, 1'b1, 3'b001, 32'h0, 1'b0, 1'b1);
    idle(32'hBEEF1234, 1'b0, 1'b1);
    check_val("lh_misaligned", wb_wdata, 32'hFFFFBEEF);
    idle(32'h0, 1'b0, 1'b1);

    // Backpressure: hold FULL for 3 cycles, then replace
    step(1'b1, 32'hAAAA, 5'd9, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hBBBB, 5'd10, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0);
      check_val("stall_wdata", wb_wdata, 32'hAAAA);
      check_val("stall_rd", wb_rd, 5'd9);
      check_val("stall_ready", me_ready, 1'b0);
    end
    step(1'b1, 32'hBBBB, 5'd10, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b1);
    check_val("replace_wdata", wb_wdata, 32'hBBBB);
    check_val("replace_rd", wb_rd, 5'd10);
    idle(32'h0, 1'b0, 1'b1);
    check_val("drained_valid", wb_valid, 1'b0);

    // Flush while waiting for load data
    step(1'b1, 32'h3000, 5'd11, 1'b1, 1'b1, 3'b010, 32'h0, 1'b0, 1'b1);
    idle(32'h12345678, 1'b1, 1'b1);
    check_val("flush_wait_valid", wb_valid, 1'b0);
    idle(32'h0, 1'b0, 1'b0);
    check_val("flush_wait_valid2", wb_valid, 1'b0);
    check_val("flush_wait_ready", me_ready, 1'b1);

    // Flush together with wb_ready while FULL: visible that cycle, gone after
    step(1'b1, 32'h4444, 5'd12, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b1);
    idle(32'h0, 1'b1, 1'b1);
    check_val("flush_full_after", wb_valid, 1'b0);

    // rd=0 writes are suppressed
    step(1'b1, 32'h5555, 5'd0, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b1);
    check_val("rd0_valid", wb_valid, 1'b1);
    check_val("rd0_we", wb_regs_write, 1'b0);
    check_val("rd0_fwd", fwd_valid, 1'b0);

    // Async reset mid-FULL
    step(1'b1, 32'h6666, 5'd13, 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0);
    check_val("pre_reset_valid", wb_valid, 1'b1);
    #1 rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    #1 rstn = 1'b1;

    // Reset during WAIT_DATA drops the load
    step(1'b1, 32'h7000, 5'd14, 1'b1, 1'b1, 3'b010, 32'h0, 1'b0, 1'b1);
    #1 rstn = 1'b0;
    #1 model_reset();
    #1 rstn = 1'b1;
    idle(32'hCAFEF00D, 1'b0, 1'b1);
    check_val("reset_wait_valid", wb_valid, 1'b0);

    // XLEN=64: LWU, LW and LD at offset 4
    step64(1'b1, 64'h104, 1'b1, 3'b110, 64'h0);
    step64(1'b0, 64'h0, 1'b0, 3'b000, 64'h80000001_DEADBEEF);
    check_val("x64_lwu", wbd64, 64'h00000000_80000001);
    check_val("x64_lwu_valid", wbv64, 1'b1);
    step64(1'b1, 64'h104, 1'b1, 3'b010, 64'h0);
    step64(1'b0, 64'h0, 1'b0, 3'b000, 64'h80000001_DEADBEEF);
    check_val("x64_lw", wbd64, 64'hFFFFFFFF_80000001);
    step64(1'b1, 64'h104, 1'b1, 3'b011, 64'h0);
    step64(1'b0, 64'h0, 1'b0, 3'b000, 64'h80000001_DEADBEEF);
    check_val("x64_ld", wbd64, 64'h80000001_DEADBEEF);
    step64(1'b0, 64'h0, 1'b0, 3'b000, 64'h0);
    check_val("x64_drained", wbv64, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
           ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
